// File: rtl/axis_tx_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axis_tx_pkt_arbiter
//  Summary  : Packet-granular 2:1 AXI-Stream arbiter for the CMAC TX path.
//             Round-robin grant on packet boundaries, lock until tlast,
//             per-source completed-packet counters.
//  Options  : AXIS_TX_ARB_OUT_REG_EN - 2-entry skid register on m_axis_*,
//             source tready decoupled from m_axis_tready.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_tx_pkt_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic [USER_WIDTH-1:0] s0_axis_tuser,

    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic [USER_WIDTH-1:0] s1_axis_tuser,

    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    input  logic [1:0]            src_en,
    output logic                  grant_valid,
    output logic                  grant_idx,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_rr_last;
    logic                  r_grant_valid;
    logic                  r_grant_idx;
    logic [31:0]           r_pkt_cnt0;
    logic [31:0]           r_pkt_cnt1;
    logic                  r_run;

    logic                  w_cand0;
    logic                  w_cand1;
    logic                  w_act;
    logic                  w_sel;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [KEEP_WIDTH-1:0] w_sel_keep;
    logic [USER_WIDTH-1:0] w_sel_user;
    logic                  w_up_ready;
    logic                  w_up_xfer;

    // Run flag: keeps every combinational output quiet while reset is held,
    // since the grant itself is a function of live source inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Grant selection: locked source, or round-robin among enabled candidates.
    always_comb begin
        w_cand0 = s0_axis_tvalid & src_en[0];
        w_cand1 = s1_axis_tvalid & src_en[1];
        w_act   = 1'b0;
        w_sel   = 1'b0;
        case (r_state)
            ST_LOCK0: begin
                w_act = 1'b1;
                w_sel = 1'b0;
            end
            ST_LOCK1: begin
                w_act = 1'b1;
                w_sel = 1'b1;
            end
            default: begin
                w_act = w_cand0 | w_cand1;
                w_sel = (w_cand0 & w_cand1) ? ~r_rr_last : w_cand1;
            end
        endcase
        w_act = w_act & r_run;
    end

    // Payload mux of the granted source; all zero when nothing is granted.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_user  = '0;
        if (w_act) begin
            if (w_sel) begin
                w_sel_valid = s1_axis_tvalid;
                w_sel_last  = s1_axis_tlast;
                w_sel_data  = s1_axis_tdata;
                w_sel_keep  = s1_axis_tkeep;
                w_sel_user  = s1_axis_tuser;
            end else begin
                w_sel_valid = s0_axis_tvalid;
                w_sel_last  = s0_axis_tlast;
                w_sel_data  = s0_axis_tdata;
                w_sel_keep  = s0_axis_tkeep;
                w_sel_user  = s0_axis_tuser;
            end
        end
    end

    assign w_up_xfer      = w_sel_valid & w_up_ready;
    assign s0_axis_tready = w_act & ~w_sel & w_up_ready;
    assign s1_axis_tready = w_act &  w_sel & w_up_ready;

`ifdef AXIS_TX_ARB_OUT_REG_EN
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [PW-1:0] r_buf [0:1];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic [PW-1:0] w_beat;
    logic          w_pop;

    assign w_beat     = {w_sel_last, w_sel_user, w_sel_keep, w_sel_data};
    // Space check depends only on occupancy, never on m_axis_tready.
    assign w_up_ready = (r_count != 2'd2);
    assign w_pop      = (r_count != 2'd0) & m_axis_tready;

    // Two-entry skid FIFO between the mux and the output port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_up_xfer) begin
                r_buf[r_wptr] <= w_beat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_up_xfer, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_axis_tvalid = (r_count != 2'd0);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = r_buf[r_rptr];
`else
    assign w_up_ready    = m_axis_tready;
    assign m_axis_tvalid = w_sel_valid;
    assign m_axis_tlast  = w_sel_last;
    assign m_axis_tdata  = w_sel_data;
    assign m_axis_tkeep  = w_sel_keep;
    assign m_axis_tuser  = w_sel_user;
`endif

    // Packet lock FSM, round-robin pointer, grant status and packet counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_IDLE;
            r_rr_last     <= 1'b1;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= 1'b0;
            r_pkt_cnt0    <= 32'd0;
            r_pkt_cnt1    <= 32'd0;
        end else if (w_up_xfer) begin
            if (w_sel_last) begin
                // End of packet (also covers 1-beat packets taken from IDLE).
                r_state       <= ST_IDLE;
                r_grant_valid <= 1'b0;
                r_rr_last     <= w_sel;
                if (w_sel) begin
                    r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
                end else begin
                    r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
                end
            end else if (r_state == ST_IDLE) begin
                r_state       <= w_sel ? ST_LOCK1 : ST_LOCK0;
                r_grant_valid <= 1'b1;
                r_grant_idx   <= w_sel;
            end
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign pkt_cnt0    = r_pkt_cnt0;
    assign pkt_cnt1    = r_pkt_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_axis_tx_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_tx_pkt_arbiter
//  Summary  : Directed self-checking bench for axis_tx_pkt_arbiter
//             (default build, combinational output path).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_tx_pkt_arbiter;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
    logic [DW-1:0] s0_axis_tdata;
    logic [KW-1:0] s0_axis_tkeep;
    logic [UW-1:0] s0_axis_tuser;
    logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
    logic [DW-1:0] s1_axis_tdata;
    logic [KW-1:0] s1_axis_tkeep;
    logic [UW-1:0] s1_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic [1:0]    src_en;
    logic          grant_valid, grant_idx;
    logic [31:0]   pkt_cnt0, pkt_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    // Output log and per-cycle monitor filled by run_traffic
    int log_src[$];
    int log_word[$];
    int log_last[$];
    int log_cyc[$];
    bit mon_gv[$];
    bit mon_gi[$];
    bit mon_t0[$];
    bit timed_out;
    int p0, p1;

    always #5 CLK = ~CLK;

    axis_tx_pkt_arbiter #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tdata(s0_axis_tdata),
        .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tdata(s1_axis_tdata),
        .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .src_en(src_en), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    // Beat encoding: tdata[12]=source, [11:4]=packet number, [3:0]=beat number
    task automatic drive_src(input int s, input bit v, input int pkt, input int beat, input bit last);
        logic [DW-1:0] d;
        d       = '0;
        d[12]   = s[0];
        d[11:4] = pkt[7:0];
        d[3:0]  = beat[3:0];
        if (s == 0) begin
            s0_axis_tvalid = v;
            s0_axis_tlast  = v & last;
            s0_axis_tdata  = v ? d : '0;
            s0_axis_tkeep  = v ? '1 : '0;
            s0_axis_tuser  = '0;
        end else begin
            s1_axis_tvalid = v;
            s1_axis_tlast  = v & last;
            s1_axis_tdata  = v ? d : '0;
            s1_axis_tkeep  = v ? '1 : '0;
            s1_axis_tuser  = '1;
        end
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        src_en = 2'b11;
        m_axis_tready = 1'b1;
        drive_src(0, 1'b0, 0, 0, 1'b0);
        drive_src(1, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Two AXIS source models honouring tready; sink ready pattern per bp_mode
    task automatic run_traffic(input int np0, input int len0, input int np1, input int len1,
                               input int bp_mode, input int clr_en0_cyc, input int max_cyc);
        int b0, b1;
        bit x0, x1;
        b0 = 0; b1 = 0; p0 = 0; p1 = 0;
        log_src.delete(); log_word.delete(); log_last.delete(); log_cyc.delete();
        mon_gv.delete(); mon_gi.delete(); mon_t0.delete();
        timed_out = 1'b1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (cyc == clr_en0_cyc) src_en[0] = 1'b0;
            drive_src(0, p0 < np0, p0, b0, b0 == len0 - 1);
            drive_src(1, p1 < np1, p1, b1, b1 == len1 - 1);
            m_axis_tready = (bp_mode == 1) ? (cyc % 2 == 0) : 1'b1;
            @(negedge CLK);
            mon_gv.push_back(grant_valid);
            mon_gi.push_back(grant_idx);
            mon_t0.push_back(s0_axis_tready);
            if (m_axis_tvalid && m_axis_tready) begin
                log_src.push_back(int'(m_axis_tdata[12]));
                log_word.push_back(int'(m_axis_tdata[11:0]));
                log_last.push_back(int'(m_axis_tlast));
                log_cyc.push_back(cyc);
            end
            x0 = s0_axis_tvalid && s0_axis_tready;
            x1 = s1_axis_tvalid && s1_axis_tready;
            @(posedge CLK);
            #1;
            if (x0) begin
                if (b0 == len0 - 1) begin b0 = 0; p0++; end else b0++;
            end
            if (x1) begin
                if (b1 == len1 - 1) begin b1 = 0; p1++; end else b1++;
            end
            if (p0 >= np0 && p1 >= np1) begin
                timed_out = 1'b0;
                break;
            end
        end
        drive_src(0, 1'b0, 0, 0, 1'b0);
        drive_src(1, 1'b0, 0, 0, 1'b0);
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        src_en = 2'b11;
        m_axis_tready = 1'b1;
        drive_src(0, 1'b1, 0, 0, 1'b0);
        drive_src(1, 1'b1, 0, 0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if ({m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, grant_valid, grant_idx} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, grant_valid, grant_idx});
        end
        n_tests++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got data[15:0]=%h keep=%h user=%h required 0",
                     m_axis_tdata[15:0], m_axis_tkeep, m_axis_tuser);
        end
        n_tests++;
        if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h required 0/0", pkt_cnt0, pkt_cnt1);
        end
        n_tests++;
        if (dut.r_rr_last !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rr_last: got %b required 1", dut.r_rr_last);
        end
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        n_tests++;
        if (s0_axis_tready !== 1'b1 || s1_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got tready0=%b tready1=%b required 1/0",
                     s0_axis_tready, s1_axis_tready);
        end
        drive_src(0, 1'b0, 0, 0, 1'b0);
        drive_src(1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_single_source();
        int exp_word;
        apply_reset();
        run_traffic(3, 4, 0, 1, 0, -1, 30);
        n_tests++;
        if (timed_out || log_src.size() != 12) begin
            n_fail++;
            $display("FAIL single_count: got %0d beats (timeout=%b) required 12", log_src.size(), timed_out);
        end
        for (int k = 0; k < log_src.size() && k < 12; k++) begin
            exp_word = ((k / 4) << 4) | (k % 4);
            n_tests++;
            if (log_src[k] !== 0 || log_word[k] !== exp_word || log_last[k] !== int'(k % 4 == 3) || log_cyc[k] !== k) begin
                n_fail++;
                $display("FAIL single_beat%0d: got src=%0d word=%h last=%0d cyc=%0d required 0 %h %0d %0d",
                         k, log_src[k], log_word[k], log_last[k], log_cyc[k], exp_word, int'(k % 4 == 3), k);
            end
        end
        n_tests++;
        if (pkt_cnt0 !== 32'd3 || pkt_cnt1 !== 32'd0) begin
            n_fail++;
            $display("FAIL single_cnt: got %0d/%0d required 3/0", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_contention();
        int exp_src, exp_word;
        apply_reset();
        run_traffic(2, 2, 2, 2, 0, -1, 20);
        n_tests++;
        if (timed_out || log_src.size() != 8) begin
            n_fail++;
            $display("FAIL cont_count: got %0d beats (timeout=%b) required 8", log_src.size(), timed_out);
        end
        for (int k = 0; k < log_src.size() && k < 8; k++) begin
            exp_src  = (k / 2) % 2;
            exp_word = ((k / 4) << 4) | (k % 2);
            n_tests++;
            if (log_src[k] !== exp_src || log_word[k] !== exp_word || log_cyc[k] !== k) begin
                n_fail++;
                $display("FAIL cont_beat%0d: got src=%0d word=%h cyc=%0d required %0d %h %0d",
                         k, log_src[k], log_word[k], log_cyc[k], exp_src, exp_word, k);
            end
        end
        n_tests++;
        if (pkt_cnt0 !== 32'd2 || pkt_cnt1 !== 32'd2) begin
            n_fail++;
            $display("FAIL cont_cnt: got %0d/%0d required 2/2", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_backpressure();
        int exp_src, exp_word, exp_cyc;
        apply_reset();
        // One 1-beat s0 packet moves the round-robin pointer to 0
        run_traffic(1, 1, 0, 1, 0, -1, 5);
        run_traffic(1, 2, 1, 5, 1, -1, 40);
        n_tests++;
        if (timed_out || log_src.size() != 7) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats (timeout=%b) required 7", log_src.size(), timed_out);
        end
        for (int k = 0; k < log_src.size() && k < 7; k++) begin
            exp_src  = (k < 5) ? 1 : 0;
            exp_word = (k < 5) ? k : (k - 5);
            exp_cyc  = 2 * k;
            n_tests++;
            if (log_src[k] !== exp_src || log_word[k] !== exp_word || log_cyc[k] !== exp_cyc) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got src=%0d word=%h cyc=%0d required %0d %h %0d",
                         k, log_src[k], log_word[k], log_cyc[k], exp_src, exp_word, exp_cyc);
            end
        end
        if (mon_gv.size() >= 10) begin
            for (int c = 0; c <= 8; c++) begin
                n_tests++;
                if (mon_t0[c] !== 1'b0 || (c >= 1 && (mon_gv[c] !== 1'b1 || mon_gi[c] !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL bp_lock_cyc%0d: got tready0=%b gv=%b gi=%b required 0 1 1",
                             c, mon_t0[c], mon_gv[c], mon_gi[c]);
                end
            end
            n_tests++;
            if (mon_gv[9] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_release: got grant_valid=%b required 0", mon_gv[9]);
            end
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL bp_monitor: got %0d cycles required >=10", mon_gv.size());
        end
    endtask

    task automatic test_enable_gating();
        apply_reset();
        run_traffic(2, 4, 1, 2, 0, 1, 14);
        n_tests++;
        if (log_src.size() != 6) begin
            n_fail++;
            $display("FAIL gate_count: got %0d beats required 6", log_src.size());
        end
        for (int k = 0; k < log_src.size() && k < 6; k++) begin
            n_tests++;
            if (log_src[k] !== ((k < 4) ? 0 : 1) || log_cyc[k] !== k) begin
                n_fail++;
                $display("FAIL gate_beat%0d: got src=%0d cyc=%0d required %0d %0d",
                         k, log_src[k], log_cyc[k], (k < 4) ? 0 : 1, k);
            end
        end
        n_tests++;
        if (p0 !== 1 || pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd1) begin
            n_fail++;
            $display("FAIL gate_cnt: got served0=%0d cnt=%0d/%0d required 1 1/1", p0, pkt_cnt0, pkt_cnt1);
        end
        n_tests++;
        if (mon_t0.size() != 14 || mon_t0[13] !== 1'b0 || mon_t0[6] !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_unserved: got %0d cycles tready0=%b required 14 cycles tready0=0",
                     mon_t0.size(), mon_t0[13]);
        end
        src_en = 2'b11;
    endtask

    task automatic test_wrap_one_beat();
        apply_reset();
        force dut.r_pkt_cnt1 = 32'hFFFF_FFFF;
        #1;
        release dut.r_pkt_cnt1;
        n_tests++;
        if (pkt_cnt1 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h required ffffffff", pkt_cnt1);
        end
        run_traffic(0, 1, 1, 1, 0, -1, 5);
        n_tests++;
        if (timed_out || pkt_cnt1 !== 32'd0 || grant_valid !== 1'b0 || mon_gv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_cnt: got cnt=%h gv=%b timeout=%b required 0 0 0", pkt_cnt1, grant_valid, timed_out);
        end
        run_traffic(0, 1, 3, 1, 0, -1, 10);
        n_tests++;
        if (timed_out || log_cyc.size() != 3 || log_cyc[2] !== 2 || log_last[1] !== 1) begin
            n_fail++;
            $display("FAIL one_beat_b2b: got %0d beats last_cyc=%0d required 3 beats last_cyc=2",
                     log_cyc.size(), log_cyc[2]);
        end
        n_tests++;
        if (mon_gv.size() != 3 || mon_gv[1] !== 1'b0 || mon_gv[2] !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL one_beat_idle: got gv=%b%b now=%b required 0", mon_gv[1], mon_gv[2], grant_valid);
        end
        n_tests++;
        if (pkt_cnt1 !== 32'd3) begin
            n_fail++;
            $display("FAIL one_beat_cnt: got %0d required 3", pkt_cnt1);
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        m_axis_tready = 1'b1;
        drive_src(1, 1'b1, 0, 0, 1'b1);
        @(posedge CLK); #1;
        drive_src(1, 1'b1, 1, 0, 1'b0);
        @(posedge CLK); #1;
        drive_src(1, 1'b1, 1, 1, 1'b0);
        @(posedge CLK); #1;
        drive_src(1, 1'b1, 1, 2, 1'b0);
        drive_src(0, 1'b1, 0, 0, 1'b0);
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || grant_valid !== 1'b1 || grant_idx !== 1'b1 ||
            pkt_cnt1 !== 32'd1 || s0_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got mv=%b gv=%b gi=%b cnt1=%0d t0=%b required 1 1 1 1 0",
                     m_axis_tvalid, grant_valid, grant_idx, pkt_cnt1, s0_axis_tready);
        end
        RST_N = 1'b0;
        #1;
        n_tests++;
        if ({m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, grant_valid, grant_idx} !== 6'b0 ||
            m_axis_tdata !== '0 || pkt_cnt1 !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got ctrl=%b data[15:0]=%h cnt1=%0d required 0",
                     {m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, grant_valid, grant_idx},
                     m_axis_tdata[15:0], pkt_cnt1);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        n_tests++;
        if (dut.r_rr_last !== 1'b1 || s0_axis_tready !== 1'b1 || s1_axis_tready !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got rr=%b t0=%b t1=%b gv=%b required 1 1 0 0",
                     dut.r_rr_last, s0_axis_tready, s1_axis_tready, grant_valid);
        end
        drive_src(0, 1'b0, 0, 0, 1'b0);
        drive_src(1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_enable_gating();
        test_wrap_one_beat();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_tx_pkt_arbiter.md
# axis_tx_pkt_arbiter

Packet-granular two-to-one AXI-Stream arbiter that shares one CMAC TX stream (512-bit, `xdma_axis`-width beats) between two requesters, e.g. XDMA H2C traffic and the UDP perf-monitor generator. It grants on packet boundaries with round-robin fairness and locks the grant until the granted packet's `tlast` beat transfers. It also exposes per-source packet counters for the perf ILA. It sits in front of the cross-die `xpm_fifo_axis` buffer feeding `CmacRxTxWrapper`.

## Interface
Parameters:
- `DATA_WIDTH`, 512: tdata width.
- `KEEP_WIDTH`, 64: tkeep width (`DATA_WIDTH/8`).
- `USER_WIDTH`, 1: tuser width.

Ports:
- `CLK`  in  1  single clock for all logic.
- `RST_N`  in  1  reset; asynchronous assert, active-low.
- `s0_axis_tvalid/tready/tlast`  in/out/in  1 each  requester 0 stream handshake and end-of-packet.
- `s0_axis_tdata/tkeep/tuser`  in  `DATA_WIDTH`/`KEEP_WIDTH`/`USER_WIDTH`  requester 0 payload.
- `s1_axis_*`  same as `s0_axis_*`  requester 1 stream.
- `m_axis_tvalid/tready/tlast`  out/in/out  1 each  arbitrated output stream.
- `m_axis_tdata/tkeep/tuser`  out  widths as above  arbitrated payload.
- `src_en`  in  2  per-source enable; bit i gates new grants to source i.
- `grant_valid`  out  1  a packet is currently locked.
- `grant_idx`  out  1  index of the locked source; valid only when `grant_valid`.
- `pkt_cnt0`, `pkt_cnt1`  out  32 each  completed packets forwarded per source.

## Operation
- State: `IDLE`, `LOCK0`, `LOCK1`, plus round-robin pointer `rr_last` (last source served).
- `IDLE`: candidate i = `s{i}_axis_tvalid & src_en[i]`.
  - One candidate: grant it.
  - Both candidates: grant `~rr_last`.
  - Grant is combinational. The first beat may transfer in the same cycle.
  - If that first beat has `tlast`, it is a 1-beat packet and the state stays `IDLE`. Otherwise go to `LOCK{i}`.
- `LOCK{i}`: output muxes source i. `s{i}_axis_tready` follows the output ready, and the other source's tready = 0. Go to `IDLE` on the handshake of a `tlast` beat.
- On every granted `tlast` transfer:
  - `rr_last <= i`.
  - `pkt_cnt{i}` increments, wrapping 0xFFFF_FFFF -> 0.
- Deasserting `src_en[i]` mid-packet does not break the lock. It blocks only the next grant.
- A source dropping `tvalid` mid-packet holds the lock, and the output sees `tvalid=0` bubbles. No timeout.
- Non-granted sources see `tready=0` and must hold their beat (AXIS rules).
- The counters are never cleared except by reset.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata/tkeep/tuser`=0.
  - `s0/s1_axis_tready`=0.
  - `grant_valid`=0, `grant_idx`=0, `pkt_cnt0/1`=0.
  - `rr_last`=1, so source 0 wins the first contention.
- Reset asserted mid-packet aborts the packet immediately. Downstream sees a truncated stream, which is acceptable because the CMAC path is reset together.
- `grant_valid`/`grant_idx` are registered. They reflect `LOCK{i}` from the cycle after the first non-last beat transfers.
- Back-to-back packets, with the other source idle: zero idle cycles between packets.
- Alternating contention: zero idle cycles between packets, strict alternation.
- Throughput is 1 beat/cycle when the source and sink are both always ready.

## Configuration
- `AXIS_TX_ARB_OUT_REG_EN` defined:
  - A 2-entry skid register sits on the `m_axis_*` outputs.
  - Source `tready` comes from register state, with no combinational path from `m_axis_tready`.
  - Latency is 1 cycle from source to output. Full throughput is kept.
  - The skid empties before reset release (reset value 0).
  - Counters increment when the `tlast` beat is accepted into the skid, not on output.
- Undefined:
  - The output is a combinational mux of the granted source, with 0-cycle latency.
  - `s{i}_axis_tready = m_axis_tready & granted(i)`.

## Test plan
- Single source: s0 sends 3 packets of 4 beats each, s1 idle, `m_axis_tready`=1. Required: 12 consecutive output beats, `pkt_cnt0`=3, `pkt_cnt1`=0, no gaps.
- Contention: both sources are continuously valid with 2-beat packets, starting after reset. Required output order by source: 0,0,1,1,0,0,1,1. No interleaving inside a packet.
- Backpressure: `m_axis_tready` toggles 1010 during a 5-beat s1 packet. Required: all 5 beats in order, s0 `tready` held 0 throughout, lock released only after `tlast`.
- Enable gating: clear `src_en[0]` mid-packet from s0. Required: that packet completes, then s1 is granted while s0 stays valid and unserved.
- Wrap and 1-beat packets: force `pkt_cnt1`=0xFFFF_FFFF, then send 1-beat packets on s1. Required: the counter reads 0 after one packet, and the state stays `IDLE` (`grant_valid`=0).
- Reset mid-packet: assert `RST_N`=0 at beat 2 of 4. Required: all outputs take their reset values asynchronously, and `rr_last`=1 after release.
